// File: rtl/ci_dispatch.sv
// ---------------------------------------------------------------------------
// ci_dispatch
//
// Front end for the Nios II custom-instruction port. One CPU CI request is
// routed to one of NUM_SLAVES CI slaves. n[7:6] selects the slave and n[5:0]
// is forwarded to it as the sub-opcode. The dispatcher registers the operands,
// pulses the slave's start, waits for its done and returns the result to the
// CPU with a one-cycle done pulse.
//
// Optional feature (macro CI_DISPATCH_TIMEOUT_EN):
//   When the macro is defined, a watchdog counts enabled BUSY cycles. After
//   TIMEOUT cycles without the selected slave's done, the request is aborted
//   with TIMEOUT_RESULT and err is set. When the macro is undefined, BUSY
//   waits indefinitely.
//
// Parameters:
//   NUM_SLAVES     number of attached CI slaves (1..4)
//   TIMEOUT        enabled BUSY cycles before a watchdog abort (>= 2)
//   TIMEOUT_RESULT result returned on a watchdog abort
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   clk_en    in   CPU CI clock enable; qualifies every state update
//   start     in   CPU CI start, one-cycle pulse
//   n         in   CPU CI opcode: [7:6] slave select, [5:0] sub-opcode
//   dataa     in   operand A
//   datab     in   operand B
//   result    out  CPU CI result, valid while done=1 and held afterwards
//   done      out  CPU CI done, one-cycle pulse
//   s_start   out  per-slave start pulse
//   s_n       out  sub-opcode to the slaves, {2'b00, n[5:0]}
//   s_dataa   out  registered operand A to the slaves
//   s_datab   out  registered operand B to the slaves
//   s_result  in   slave results, slave i at [32*i+31:32*i]
//   s_done    in   per-slave done
//   err       out  sticky error flag (bad select or watchdog abort)
// ---------------------------------------------------------------------------
module ci_dispatch #(
  parameter int          NUM_SLAVES     = 4,
  parameter int          TIMEOUT        = 64,
  parameter logic [31:0] TIMEOUT_RESULT = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clk_en,
  input  logic                       start,
  input  logic [7:0]                 n,
  input  logic [31:0]                dataa,
  input  logic [31:0]                datab,
  output logic [31:0]                result,
  output logic                       done,
  output logic [NUM_SLAVES-1:0]      s_start,
  output logic [7:0]                 s_n,
  output logic [31:0]                s_dataa,
  output logic [31:0]                s_datab,
  input  logic [32*NUM_SLAVES-1:0]   s_result,
  input  logic [NUM_SLAVES-1:0]      s_done,
  output logic                       err
);

  // Elaboration-time guards on the parameter ranges.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 4) begin : g_bad_num_slaves
    $error("ci_dispatch: NUM_SLAVES must be in 1..4");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("ci_dispatch: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [1:0]              r_sel;
  logic [7:0]              r_s_n;
  logic [31:0]             r_dataa;
  logic [31:0]             r_datab;
  logic [31:0]             r_result;
  logic                    r_err;

  logic                    w_sel_ok;
  logic [NUM_SLAVES-1:0]   w_sel_oh;
  logic [31:0]             w_sel_result;
  logic                    w_sel_done;
  logic                    w_accept;
  logic                    w_timeout;

  // Range check on the incoming select; widened so NUM_SLAVES=4 fits.
  assign w_sel_ok = ({1'b0, n[7:6]} < 3'(NUM_SLAVES));
  assign w_accept = (r_state == IDLE) && start;

  // Decode the latched select into a one-hot mask and pick that slave's
  // result. Looping over the existing slaves only keeps every index in range
  // even when NUM_SLAVES < 4.
  always_comb begin
    w_sel_oh     = '0;
    w_sel_result = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == 2'(i)) begin
        w_sel_oh[i]  = 1'b1;
        w_sel_result = s_result[32*i +: 32];
      end
    end
  end

  // Done bits of unselected slaves are masked off here.
  assign w_sel_done = |(s_done & w_sel_oh);

`ifdef CI_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wdog;

  // The abort fires on the enabled BUSY cycle in which the count would reach
  // TIMEOUT, so exactly TIMEOUT BUSY cycles elapse before RESP.
  assign w_timeout = (r_wdog == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (clk_en) begin
      if (r_state == ISSUE) begin
        r_wdog <= '0;
      end else if (r_state == BUSY && !w_sel_done) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A slave done seen in ISSUE is ignored: the slave has
  // not sampled its start yet, so it cannot be answering this request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_sel_ok ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_sel_done || w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request capture, result capture and the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel    <= '0;
      r_s_n    <= '0;
      r_dataa  <= '0;
      r_datab  <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (clk_en) begin
      if (w_accept) begin
        r_sel   <= n[7:6];
        r_s_n   <= {2'b00, n[5:0]};
        r_dataa <= dataa;
        r_datab <= datab;
        if (!w_sel_ok) begin
          r_result <= '0;
          r_err    <= 1'b1;
        end
      end
      if (r_state == BUSY) begin
        // A real answer wins over an abort arriving in the same cycle.
        if (w_sel_done) begin
          r_result <= w_sel_result;
        end else if (w_timeout) begin
          r_result <= TIMEOUT_RESULT;
          r_err    <= 1'b1;
        end
      end
    end
  end

  // Pulses are suppressed while clk_en is low so a frozen FSM never
  // re-signals; they reappear on the next enabled cycle.
  assign done    = clk_en && (r_state == RESP);
  assign s_start = (clk_en && (r_state == ISSUE)) ? w_sel_oh : '0;

  assign result  = r_result;
  assign s_n     = r_s_n;
  assign s_dataa = r_dataa;
  assign s_datab = r_datab;
  assign err     = r_err;

endmodule

// File: tb/tb_ci_dispatch.sv
// ---------------------------------------------------------------------------
// tb_ci_dispatch
//
// Self-checking bench for ci_dispatch with three slaves (so select 3 is a bad
// select) and TIMEOUT=8. Each CI request is described at transaction level:
// the expected handshake timing, result and error flag follow from the
// request's rules (latched operands, one-cycle start, result after the
// selected slave's enabled done, sticky error). The bench plays the slaves.
// Works with or without CI_DISPATCH_TIMEOUT_EN defined.
// ---------------------------------------------------------------------------
module tb_ci_dispatch;

  localparam int          NS = 3;
  localparam int          TO = 8;
  localparam logic [31:0] TR = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clk_en;
  logic              start;
  logic [7:0]        n;
  logic [31:0]       dataa;
  logic [31:0]       datab;
  logic [31:0]       result;
  logic              done;
  logic [NS-1:0]     s_start;
  logic [7:0]        s_n;
  logic [31:0]       s_dataa;
  logic [31:0]       s_datab;
  logic [32*NS-1:0]  s_result;
  logic [NS-1:0]     s_done;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Reference state: the sticky error and the last returned result.
  logic        exp_err;
  logic [31:0] exp_res;

  ci_dispatch #(
    .NUM_SLAVES     (NS),
    .TIMEOUT        (TO),
    .TIMEOUT_RESULT (TR)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .start    (start),
    .n        (n),
    .dataa    (dataa),
    .datab    (datab),
    .result   (result),
    .done     (done),
    .s_start  (s_start),
    .s_n      (s_n),
    .s_dataa  (s_dataa),
    .s_datab  (s_datab),
    .s_result (s_result),
    .s_done   (s_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_results();
    for (int i = 0; i < NS; i++) s_result[32*i +: 32] = $urandom;
  endtask

  // One CI request. mode 0: random clk_en gaps, stray starts and stray slave
  // dones; mode 1: clk_en held low across the whole BUSY fill while the
  // selected slave pulses done; mode 2: clean handshake. fill is the number
  // of BUSY cycles before the slave answers.
  task automatic run_op(input logic [1:0] sel, input logic [5:0] sub,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int fill, input int mode);
    int en_cnt;
    int isel;
    isel   = int'(sel);
    start  = 1'b1;
    n      = {sel, sub};
    dataa  = a;
    datab  = b;
    clk_en = 1'b1;
    s_done = '0;
    #1;
    check("idle_done", 32'(done), 32'd0);
    check("idle_err", 32'(err), 32'(exp_err));
    check("idle_result", result, exp_res);
    tick();
    start = (mode == 0) ? 1'($urandom) : 1'b0;
    n     = 8'($urandom);
    dataa = $urandom;
    datab = $urandom;
    if (isel >= NS) begin
      exp_err = 1'b1;
      exp_res = '0;
      #1;
      check("bad_done", 32'(done), 32'd1);
      check("bad_result", result, 32'd0);
      check("bad_err", 32'(err), 32'd1);
      check("bad_s_start", 32'(s_start), 32'd0);
      tick();
      start = 1'b0;
      #1;
      check("bad_done_pulse", 32'(done), 32'd0);
      return;
    end
    if (mode == 0) begin
      repeat ($urandom_range(0, 2)) begin
        clk_en = 1'b0;
        s_done = NS'($urandom);
        #1;
        check("issue_hold_s_start", 32'(s_start), 32'd0);
        check("issue_hold_done", 32'(done), 32'd0);
        tick();
      end
    end
    // ISSUE cycle: any slave done here must be ignored.
    clk_en = 1'b1;
    s_done = (mode == 0) ? NS'($urandom) : '0;
    #1;
    check("s_start", 32'(s_start), 32'd1 << isel);
    check("s_n", 32'(s_n), 32'({2'b00, sub}));
    check("s_dataa", s_dataa, a);
    check("s_datab", s_datab, b);
    check("issue_done", 32'(done), 32'd0);
    tick();
    en_cnt = 0;
    for (int k = 0; k < fill; k++) begin
      case (mode)
        0:       clk_en = (en_cnt < 5) ? 1'($urandom) : 1'b0;
        1:       clk_en = 1'b0;
        default: clk_en = 1'b1;
      endcase
      if (clk_en) en_cnt++;
      s_done = (mode == 2) ? '0 : NS'($urandom);
      if (clk_en) s_done[isel] = 1'b0;
      else if (mode == 1) s_done[isel] = 1'b1;
      rand_results();
      start = (mode == 0) ? 1'($urandom) : 1'b0;
      #1;
      check("busy_done", 32'(done), 32'd0);
      check("busy_s_start", 32'(s_start), 32'd0);
      tick();
    end
    clk_en = 1'b1;
    s_done = (mode == 2) ? '0 : NS'($urandom);
    s_done[isel] = 1'b1;
    rand_results();
    s_result[32*isel +: 32] = r;
    start = (mode == 0) ? 1'($urandom) : 1'b0;
    #1;
    check("answer_cycle_done", 32'(done), 32'd0);
    tick();
    exp_res = r;
    s_done  = '0;
    start   = 1'b0;
    rand_results();
    if (mode == 0) begin
      repeat ($urandom_range(0, 2)) begin
        clk_en = 1'b0;
        #1;
        check("resp_hold_done", 32'(done), 32'd0);
        tick();
      end
    end
    clk_en = 1'b1;
    #1;
    check("done", 32'(done), 32'd1);
    check("result", result, r);
    check("resp_err", 32'(err), 32'(exp_err));
    check("resp_s_dataa", s_dataa, a);
    tick();
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("result_hold", result, r);
  endtask

  initial begin
    int seen;
    reset_n  = 1'b0;
    clk_en   = 1'b0;
    start    = 1'b0;
    n        = '0;
    dataa    = '0;
    datab    = '0;
    s_done   = '0;
    s_result = '0;
    exp_err  = 1'b0;
    exp_res  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_start", 32'(s_start), 32'd0);
    check("rst_s_n", 32'(s_n), 32'd0);
    check("rst_s_dataa", s_dataa, 32'd0);
    check("rst_s_datab", s_datab, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    clk_en  = 1'b1;
    tick();

    // Slave 0 answers 3 cycles after its start.
    run_op(2'd0, 6'h05, 32'h0000_00F0, 32'd4, 32'h0000_0F00, 2, 2);
    // Slave 2 with clk_en low for 5 BUSY cycles while its done pulses.
    run_op(2'd2, 6'h11, 32'h1234_5678, 32'h9ABC_DEF0, 32'hCAFE_F00D, 5, 1);
    // Bad select (n=8'hC1), then err must stay set across good requests.
    run_op(2'd3, 6'h01, 32'h1, 32'h2, 32'h0, 0, 2);
    run_op(2'd1, 6'h3F, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0BAD_CAFE, 1, 2);
    // Slave 0 with stray starts and stray dones from the other slaves.
    run_op(2'd0, 6'h22, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h7777_1111, 6, 0);

    for (int t = 0; t < 40; t++) begin
      run_op(2'($urandom_range(0, 3)), 6'($urandom), $urandom, $urandom,
             $urandom, $urandom_range(0, 8), 0);
    end

    // Slave 1 never answers.
    start  = 1'b1;
    n      = {2'd1, 6'h2A};
    dataa  = 32'h1111_2222;
    datab  = 32'h3333_4444;
    clk_en = 1'b1;
    s_done = '0;
    #1;
    tick();
    start = 1'b0;
    #1;
    check("to_s_start", 32'(s_start), 32'd2);
    tick();
`ifdef CI_DISPATCH_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      #1;
      check("to_wait_done", 32'(done), 32'd0);
      tick();
    end
    exp_err = 1'b1;
    exp_res = TR;
    #1;
    check("to_done", 32'(done), 32'd1);
    check("to_result", result, TR);
    check("to_err", 32'(err), 32'd1);
    tick();
    s_done = 3'b010;
    #1;
    check("late_done_idle", 32'(done), 32'd0);
    tick();
    s_done = '0;
    #1;
    check("late_done_ignored", 32'(done), 32'd0);
    check("late_result_hold", result, TR);
    // Put slave 0 into BUSY for the reset-mid-operation case.
    start = 1'b1;
    n     = 8'h07;
    tick();
    start = 1'b0;
    tick();
    tick();
`else
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (done) seen++;
      tick();
    end
    check("no_timeout_done", 32'(seen), 32'd0);
`endif

    // Reset while BUSY: outputs clear at once, without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    exp_err = 1'b0;
    exp_res = '0;
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_s_start", 32'(s_start), 32'd0);
    check("mid_rst_s_n", 32'(s_n), 32'd0);
    check("mid_rst_s_dataa", s_dataa, 32'd0);
    check("mid_rst_s_datab", s_datab, 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    tick();
    reset_n = 1'b1;
    start   = 1'b0;
    s_done  = '0;
    #1;
    check("post_rst_done", 32'(done), 32'd0);
    tick();

    run_op(2'd0, 6'h09, 32'hDEAD_0001, 32'hBEEF_0002, 32'h0000_ABCD, 3, 2);
    for (int t = 0; t < 10; t++) begin
      run_op(2'($urandom_range(0, 2)), 6'($urandom), $urandom, $urandom,
             $urandom, $urandom_range(0, 8), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #500000;
    $display("FAIL sim_timeout: got no end of stimulus expected finish");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule

// File: doc/ci_dispatch.md
Name: ci_dispatch

Overview:
- Upstream front end for the Nios II custom-instruction port: a single CPU CI request is routed to one of several fixed- or variable-latency CI slaves (shift unit and its siblings).
- n[7:6] selects the slave; n[5:0] is forwarded as the slave's sub-opcode.
- Operands are registered, the slave's start is pulsed, done is awaited, and the result is returned to the CPU with a one-cycle done pulse.
- Optional watchdog aborts hung slaves.

Parameters:
- NUM_SLAVES, 4, number of attached CI slaves (1..4).
- TIMEOUT, 64, BUSY cycles (with clk_en high) before watchdog abort; must be >= 2.
- TIMEOUT_RESULT, 32'hDEADBEEF, result returned on watchdog abort.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  CPU CI clock enable
- start  in  1  CPU CI start, one-cycle pulse
- n  in  8  CPU CI opcode; [7:6] slave select, [5:0] sub-opcode
- dataa  in  32  operand A
- datab  in  32  operand B
- result  out  32  CPU CI result, valid while done=1
- done  out  1  CPU CI done, one-cycle pulse
- s_start  out  NUM_SLAVES  per-slave start pulse
- s_n  out  8  sub-opcode to slaves, {2'b00, n[5:0]}
- s_dataa  out  32  operand A to slaves (registered)
- s_datab  out  32  operand B to slaves (registered)
- s_result  in  32*NUM_SLAVES  slave results, slave i at [32*i+31:32*i]
- s_done  in  NUM_SLAVES  per-slave done
- err  out  1  sticky error flag: bad select or timeout

Behaviour:
- Reset (reset_n low, async): state=IDLE; result=0, done=0, s_start=0, s_n=0, s_dataa=0, s_datab=0, err=0, sel=0, watchdog counter=0. Reset mid-operation abandons the request; no done is produced.
- All state updates are qualified by clk_en. clk_en low freezes the FSM, counter and registers. done and s_start are forced to 0 while clk_en is low, and resume on the next enabled cycle.
- State IDLE:
  - On start & clk_en: capture sel=n[7:6], s_n, s_dataa, s_datab.
  - If sel < NUM_SLAVES: go to ISSUE.
  - Otherwise: go to RESP with result=0 and set err.
- State ISSUE (1 cycle): s_start[sel]=1, all other s_start bits 0; clear watchdog counter; go to BUSY.
- State BUSY:
  - s_done[sel] & clk_en: capture s_result[sel] into result; go to RESP.
  - s_done bits of unselected slaves are ignored.
- State RESP (1 cycle): done=1 with result stable; go to IDLE. result holds its value until the next capture.
- Latency: start at edge T gives s_start high in cycle T+1. A slave done sampled at edge D gives CPU done high in cycle D+1. Bad select gives done in cycle T+1.
- start asserted outside IDLE is ignored: no queueing, err unaffected.
- s_done[sel] in the ISSUE cycle is ignored, since a slave cannot complete before it samples start.
- s_dataa, s_datab and s_n stay stable from ISSUE until the next accepted start.
- err clears only on reset.

Optional Feature:
- Macro CI_DISPATCH_TIMEOUT_EN.
- Defined:
  - BUSY increments the watchdog counter on each clk_en cycle.
  - If it reaches TIMEOUT without s_done[sel]: result=TIMEOUT_RESULT, go to RESP, set err.
  - A late s_done from the aborted slave arriving in IDLE is ignored.
- Undefined: no counter logic; BUSY waits indefinitely; err is set only by a bad select.

Test Plan:
- Start with n=8'h05, dataa=32'h0000_00F0, datab=4; slave 0 returns done 3 cycles after s_start with 32'h0000_0F00 -> s_start=4'b0001 for one cycle, s_n=8'h05, done pulses once with result=32'h0000_0F00, err=0.
- Start with n=8'hC1, NUM_SLAVES=3 -> no s_start; done in the next cycle with result=0; err=1 and it stays 1 across later good operations.
- Slave 2 selected; clk_en held low for 5 cycles while BUSY, with s_done[2] pulsed during that window -> no capture and no done; a later s_done[2] with clk_en=1 completes normally.
- With CI_DISPATCH_TIMEOUT_EN, TIMEOUT=8, slave 1 never done -> done after 8 BUSY cycles with result=32'hDEADBEEF, err=1; a late s_done[1] is ignored. Without the macro: no done within 100 cycles.
- reset_n dropped during BUSY -> all outputs 0 immediately; after release, a fresh start to slave 0 completes normally.
- A second start during BUSY, and s_done[3] while slave 0 is active -> both ignored; only s_done[0] produces done.
